spi_resp: RTL
=============

SPI_RESP -- requirements
Module: spi_resp

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-low.
REQ-002 Ports SHALL be:
  clk       in   1   system clock
  rst_n     in   1   async active-low reset
  SS_n      in   1   SPI select from initiator, active low, asynchronous to clk
  SCLK      in   1   SPI clock from initiator, asynchronous to clk
  MOSI      in   1   initiator-to-responder serial data
  MISO      out  1   responder-to-initiator serial data, MSB first
  pos_edge  in   1   1 = sample MOSI on SCLK rise and drive MISO on fall; 0 = the opposite
  width8    in   1   1 = 8-bit frame, 0 = 16-bit frame
  tx_data   in   16  response word
  wrt       in   1   one-cycle strobe; loads tx_data into the response buffer
  rx_data   out  16  last complete received frame
  rdy       out  1   one-cycle pulse when rx_data updates
  err       out  1   one-cycle pulse on aborted frame
REQ-003 pos_edge and width8 SHALL be held stable while SS_n is low; changes mid-frame are undefined.

Function
REQ-004 SS_n, SCLK and MOSI SHALL pass through a 2-flop synchronizer, then a third flop, before any use; rise and fall are detected on the last two flops.
REQ-005 Sample edge = synchronized SCLK rise if pos_edge=1, fall if pos_edge=0; drive edge = the other SCLK edge.
REQ-006 States SHALL be IDLE, SHIFT, DONE.
REQ-007 IDLE -> SHIFT on synchronized SS_n fall; at that transition: shift register <= response buffer, bit count <= 0.
REQ-008 In width8, the shift register SHALL load tx buffer[15:8] into its top byte, so MISO first presents buffer bit 15 in both widths.
REQ-009 In SHIFT, each sample edge SHALL shift synchronized MOSI into the received-data register LSB and increment the bit count.
REQ-010 In SHIFT, each drive edge SHALL shift the transmit register left by one, but only after at least one sample edge in the current frame; this blocks a premature shift on a leading drive edge.
REQ-011 Sample edges after N bits (N = 8 or 16) SHALL be ignored until SS_n rises.
REQ-012 MISO SHALL equal transmit register bit 15 in SHIFT and 0 otherwise.
REQ-013 SHIFT -> DONE on synchronized SS_n rise.
REQ-014 In DONE, if count == N:
  - rx_data <= received bits; width8 gives {8'h00, byte}
  - rdy pulses for exactly one cycle
REQ-015 In DONE, if count != N: rx_data is unchanged and err pulses for exactly one cycle; never both rdy and err.
REQ-016 DONE -> IDLE unconditionally after one cycle.
REQ-017 rdy/err latency SHALL be 4 clk cycles from the SS_n pin rising edge: 3 flops plus the DONE cycle.
REQ-018 wrt SHALL load the response buffer only in IDLE; wrt in SHIFT/DONE SHALL be ignored.
REQ-019 wrt coincident with the SS_n fall detection SHALL load the buffer, and the new value SHALL be the one shifted out.
REQ-020 The response buffer SHALL persist across frames until the next accepted wrt.
REQ-021 SCLK edges while in IDLE SHALL have no effect.

Reset
REQ-022 On rst_n low, immediately and regardless of state:
  - state = IDLE
  - rx_data = 0, buffer = 0, MISO = 0, rdy = 0, err = 0
  - synchronizer flops for SS_n = 1, for SCLK/MOSI = 0
REQ-023 Reset mid-frame SHALL discard the frame with no rdy or err pulse.
REQ-024 After reset release, the block SHALL require a fresh SS_n fall before shifting; a frame already in progress is ignored until SS_n rises.

Structure
REQ-025 Shared package spi_pkg SHALL hold:
  - FRAME_W = 16 and BYTE_W = 8
  - the state enum type
REQ-026 A sub-module spi_sync SHALL implement the 3-flop synchronizer with rise/fall outputs, instantiated for SS_n, SCLK and MOSI; parameterized reset value.
REQ-027 Expected RTL size is 150-300 lines; no clock is derived from SCLK.

Verification
REQ-028 The bench SHALL pair spi_resp with the existing SPI_TX, using clk period 10 ns; MISO is captured on SPI_TX's sample edge.
REQ-029 Directed scenarios:
  - wrt with tx_data=16'h1234, then SPI_TX sends 16'hABCD, width8=0, pos_edge=1 -> rx_data=16'hABCD; single rdy pulse 4 cycles after SS_n rises; captured MISO = 16'h1234.
  - Same with pos_edge=0 and tx_data=16'hA5C3 -> rx_data=16'hABCD; MISO = 16'hA5C3.
  - width8=1, tx_data=16'hCDAB, SPI_TX sends 16'hCDAB -> rx_data=16'h00CD; MISO byte = 8'hCD.
  - SS_n forced high after 5 SCLK periods -> err one cycle; rdy=0; rx_data keeps its previous value.
  - wrt with 16'hFFFF mid-frame -> ignored; current frame still returns the old buffer; next frame is unchanged until wrt in IDLE.
  - rst_n pulsed low during bit 9 -> all outputs 0 at once; no rdy/err; the next full frame of 16'h0F0F gives rx_data=16'h0F0F.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, state type and frame-load helper for the SPI responder
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Value placed in the transmit shifter at frame start; bit 15 always goes out first
  function automatic logic [FRAME_W-1:0] frame_load(input logic [FRAME_W-1:0] buf_val,
                                                    input logic                w8);
    frame_load = w8 ? {buf_val[FRAME_W-1:BYTE_W], {BYTE_W{1'b0}}} : buf_val;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - 2-flop synchronizer plus delay flop with rise/fall detection
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Bring the asynchronous pin into the clk domain and keep one extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s3;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_resp.sv
// rtl/spi_resp.sv - SPI responder: oversampled SS_n/SCLK/MOSI, 8/16-bit frames, rdy/err pulses
module spi_resp
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  input  logic               pos_edge,
  input  logic               width8,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               wrt,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rdy,
  output logic               err
);

  logic ss_q, ss_rise, ss_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .din(SS_n), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(MOSI), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_q, mosi_rise, mosi_fall};

  state_t             state;
  logic [FRAME_W-1:0] tx_buf;
  logic [FRAME_W-1:0] tx_sr;
  logic [FRAME_W-1:0] rx_sr;
  logic [4:0]         count;
  logic [1:0]         prime;
  logic               armed;
  logic [4:0]         nbits;
  logic               sample;
  logic               drive;

  assign nbits  = width8 ? 5'(BYTE_W) : 5'(FRAME_W);
  assign sample = pos_edge ? sclk_rise : sclk_fall;
  assign drive  = pos_edge ? sclk_fall : sclk_rise;
  assign MISO   = (state == SHIFT) & tx_sr[FRAME_W-1];

  // Arm frame detection only once the synchronizer holds a real pin sample showing SS_n high,
  // so a frame already running when reset releases is ignored until SS_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime <= 2'd0;
      armed <= 1'b0;
    end else if (prime != 2'd3) begin
      prime <= prime + 2'd1;
    end else if (ss_q) begin
      armed <= 1'b1;
    end
  end

  // Frame FSM: load on select, shift on SCLK edges, report completion or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_buf  <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      count   <= '0;
      rx_data <= '0;
      rdy     <= 1'b0;
      err     <= 1'b0;
    end else begin
      rdy <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (wrt) tx_buf <= tx_data;
          if (ss_fall && armed) begin
            state <= SHIFT;
            count <= '0;
            tx_sr <= frame_load(wrt ? tx_data : tx_buf, width8);
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state <= DONE;
          end else begin
            if (sample && (count < nbits)) begin
              rx_sr <= {rx_sr[FRAME_W-2:0], mosi_q};
              count <= count + 5'd1;
            end
            // A drive edge before the first sample edge must not consume bit 15
            if (drive && (count != 5'd0)) tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
          end
        end
        DONE: begin
          state <= IDLE;
          if (count == nbits) begin
            rx_data <= width8 ? {{(FRAME_W-BYTE_W){1'b0}}, rx_sr[BYTE_W-1:0]} : rx_sr;
            rdy     <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
